// File: rtl/pacman_pkg.sv
// Shared codes for the play-field logic: headings, scenes and ghost states.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    START = 2'b00,
    PLAY  = 2'b01,
    WIN   = 2'b10,
    LOSE  = 2'b11
  } scene_e;

  typedef enum logic [1:0] {
    CHASE   = 2'b00,
    FRIGHT  = 2'b01,
    RESPAWN = 2'b10
  } ghost_state_e;

endpackage

// File: rtl/ghost_move_multi_if.sv
// Bundle between the ghost AI / renderer side and the multi-ghost position engine.
interface ghost_move_multi_if
  import pacman_pkg::*;
#(
  parameter int unsigned MAP_W   = 18,
  parameter int unsigned MAP_H   = 5,
  parameter int unsigned N_GHOST = 4
) ();

  localparam int unsigned XW = $clog2(MAP_W);
  localparam int unsigned YW = $clog2(MAP_H);

  scene_e                   scene;
  logic                     step;
  logic [0:MAP_W*MAP_H-1]   map;
  logic [2*N_GHOST-1:0]     dir_req;
  logic [N_GHOST-1:0]       go_home;
  logic [N_GHOST-1:0]       frightened;
  logic [XW*N_GHOST-1:0]    ghost_x;
  logic [YW*N_GHOST-1:0]    ghost_y;
  logic [2*N_GHOST-1:0]     ghost_dir;
  logic [N_GHOST-1:0]       blocked;
  logic [N_GHOST-1:0]       moved;

  modport master (
    output scene, step, map, dir_req, go_home, frightened,
    input  ghost_x, ghost_y, ghost_dir, blocked, moved
  );

  modport slave (
    input  scene, step, map, dir_req, go_home, frightened,
    output ghost_x, ghost_y, ghost_dir, blocked, moved
  );

endinterface

// File: rtl/ghost_move_multi_chan.sv
// One ghost channel: chase/fright/respawn FSM, respawn counter, tile legality and position registers.
module ghost_chan
  import pacman_pkg::*;
#(
  parameter int unsigned MAP_W         = 18,
  parameter int unsigned MAP_H         = 5,
  parameter int unsigned HOME_X        = 7,
  parameter int unsigned HOME_Y        = 0,
  parameter int unsigned WRAP          = 1,
  parameter int unsigned RESPAWN_STEPS = 8,
  localparam int unsigned XW           = $clog2(MAP_W),
  localparam int unsigned YW           = $clog2(MAP_H)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  scene_e                 scene,
  input  logic                   step,
  input  logic [0:MAP_W*MAP_H-1] map,
  input  logic [1:0]             dir_req,
  input  logic                   go_home,
  input  logic                   frightened,
  output logic [XW-1:0]          x,
  output logic [YW-1:0]          y,
  output logic [1:0]             dir,
  output logic                   blocked,
  output logic                   moved
);

  localparam int unsigned IDXW = XW + YW + 1;
  localparam int unsigned MIW  = $clog2(MAP_W * MAP_H);
  localparam int unsigned CW   = (RESPAWN_STEPS > 0) ? $clog2(RESPAWN_STEPS + 1) : 1;

  ghost_state_e  state;
  logic [CW-1:0] cnt;
  logic          phase;

  logic          req_ok_c, head_ok_c;
  logic [XW-1:0] req_x_c, head_x_c;
  logic [YW-1:0] req_y_c, head_y_c;

  // Target tile for one heading; edges are rejected before the map is indexed.
  function automatic void target(input dir_e d, input logic [XW-1:0] cx, input logic [YW-1:0] cy,
                                 output logic ok, output logic [XW-1:0] tx, output logic [YW-1:0] ty);
    logic            in_range;
    logic [IDXW-1:0] idx;
    tx       = cx;
    ty       = cy;
    in_range = 1'b1;
    case (d)
      UP:    if (cy == '0) in_range = 1'b0; else ty = cy - YW'(1);
      DOWN:  if (cy == YW'(MAP_H - 1)) in_range = 1'b0; else ty = cy + YW'(1);
      LEFT:  if (cx == '0) begin
               if (WRAP != 0) tx = XW'(MAP_W - 1); else in_range = 1'b0;
             end else tx = cx - XW'(1);
      RIGHT: if (cx == XW'(MAP_W - 1)) begin
               if (WRAP != 0) tx = '0; else in_range = 1'b0;
             end else tx = cx + XW'(1);
    endcase
    idx = IDXW'(ty) * IDXW'(MAP_W) + IDXW'(tx);
    ok  = in_range && (idx < IDXW'(MAP_W * MAP_H)) && !map[idx[MIW-1:0]];
  endfunction

  // Candidate moves: the requested direction first, the latched heading as fallback.
  always_comb begin
    req_ok_c  = 1'b0;
    head_ok_c = 1'b0;
    req_x_c   = x;
    req_y_c   = y;
    head_x_c  = x;
    head_y_c  = y;
    target(dir_e'(dir_req), x, y, req_ok_c, req_x_c, req_y_c);
    target(dir_e'(dir), x, y, head_ok_c, head_x_c, head_y_c);
  end

  // State, counter, phase and position registers with start/home/play priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= XW'(HOME_X);
      y       <= YW'(HOME_Y);
      dir     <= UP;
      blocked <= 1'b0;
      moved   <= 1'b0;
      state   <= RESPAWN;
      cnt     <= CW'(RESPAWN_STEPS);
      phase   <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (scene == START) begin
        x       <= XW'(HOME_X);
        y       <= YW'(HOME_Y);
        dir     <= UP;
        blocked <= 1'b0;
        state   <= RESPAWN;
        cnt     <= CW'(RESPAWN_STEPS);
        phase   <= 1'b0;
      end else if (go_home) begin
        x     <= XW'(HOME_X);
        y     <= YW'(HOME_Y);
        dir   <= UP;
        state <= RESPAWN;
        cnt   <= CW'(RESPAWN_STEPS);
        phase <= 1'b0;
      end else if (scene == PLAY) begin
        case (state)
          RESPAWN: begin
            if (step) begin
              if (cnt <= CW'(1)) begin
                cnt   <= '0;
                phase <= 1'b0;
                state <= frightened ? FRIGHT : CHASE;
              end else begin
                cnt <= cnt - CW'(1);
              end
            end
          end
          default: begin
            if (state == CHASE && frightened) begin
              state <= FRIGHT;
              phase <= 1'b0;
            end else if (state == FRIGHT && !frightened) begin
              state <= CHASE;
            end
            if (state == FRIGHT && step) phase <= ~phase;
            // Chase moves every step; fright only when the phase bit was set.
            if (step && (state == CHASE || phase)) begin
              if (req_ok_c) begin
                x       <= req_x_c;
                y       <= req_y_c;
                dir     <= dir_req;
                moved   <= 1'b1;
                blocked <= 1'b0;
              end else if (head_ok_c) begin
                x       <= head_x_c;
                y       <= head_y_c;
                moved   <= 1'b1;
                blocked <= 1'b0;
              end else begin
                blocked <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ghost_move_multi.sv
// Multi-ghost position engine: one independent channel per ghost, sliced onto the shared bus.
module ghost_move_multi
  import pacman_pkg::*;
#(
  parameter int unsigned MAP_W         = 18,
  parameter int unsigned MAP_H         = 5,
  parameter int unsigned N_GHOST       = 4,
  localparam int unsigned XW           = $clog2(MAP_W),
  localparam int unsigned YW           = $clog2(MAP_H),
  parameter logic [XW*N_GHOST-1:0] HOME_X = {N_GHOST{XW'(7)}},
  parameter logic [YW*N_GHOST-1:0] HOME_Y = {N_GHOST{YW'(0)}},
  parameter int unsigned WRAP          = 1,
  parameter int unsigned RESPAWN_STEPS = 8
) (
  input logic               clk,
  input logic               rst_n,
  ghost_move_multi_if.slave bus
);

  // One channel per ghost; ghost k owns slice k of every packed field.
  for (genvar k = 0; k < N_GHOST; k++) begin : g_ghost
    ghost_chan #(
      .MAP_W         (MAP_W),
      .MAP_H         (MAP_H),
      .HOME_X        (int'(HOME_X[k*XW +: XW])),
      .HOME_Y        (int'(HOME_Y[k*YW +: YW])),
      .WRAP          (WRAP),
      .RESPAWN_STEPS (RESPAWN_STEPS)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .scene      (bus.scene),
      .step       (bus.step),
      .map        (bus.map),
      .dir_req    (bus.dir_req[2*k +: 2]),
      .go_home    (bus.go_home[k]),
      .frightened (bus.frightened[k]),
      .x          (bus.ghost_x[k*XW +: XW]),
      .y          (bus.ghost_y[k*YW +: YW]),
      .dir        (bus.ghost_dir[2*k +: 2]),
      .blocked    (bus.blocked[k]),
      .moved      (bus.moved[k])
    );
  end

endmodule

// File: tb/tb_ghost_move_multi.sv
// Directed bench for ghost_move_multi: respawn, heading memory, walls, tunnel, fright, home, freeze.
module tb_ghost_move_multi;
  import pacman_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  ghost_move_multi_if #(.MAP_W(18), .MAP_H(5), .N_GHOST(4)) bus ();
  ghost_move_multi_if #(.MAP_W(18), .MAP_H(5), .N_GHOST(4)) bus0 ();

  ghost_move_multi #(.WRAP(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  ghost_move_multi #(.WRAP(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  // The no-wrap copy sees identical stimulus.
  assign bus0.scene      = bus.scene;
  assign bus0.step       = bus.step;
  assign bus0.map        = bus.map;
  assign bus0.dir_req    = bus.dir_req;
  assign bus0.go_home    = bus.go_home;
  assign bus0.frightened = bus.frightened;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_step();
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
  endtask

  task automatic set_dir(input logic [1:0] d);
    bus.dir_req = {4{d}};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++;
    if (bus.ghost_x !== {4{5'd7}}) $display("FAIL reset_x got %h want %h", bus.ghost_x, {4{5'd7}});
    else n_pass++;
    n_total++;
    if (bus.ghost_y !== 12'd0) $display("FAIL reset_y got %h want 0", bus.ghost_y);
    else n_pass++;
    n_total++;
    if (bus.ghost_dir !== 8'd0) $display("FAIL reset_dir got %h want 0", bus.ghost_dir);
    else n_pass++;
    n_total++;
    if (bus.blocked !== 4'd0 || bus.moved !== 4'd0)
      $display("FAIL reset_flags got blocked=%b moved=%b want 0/0", bus.blocked, bus.moved);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.scene = PLAY;
  endtask

  task automatic test_respawn();
    set_dir(LEFT);
    for (int i = 1; i <= 8; i++) begin
      pulse_step();
      n_total++;
      if (bus.ghost_x[4:0] !== 5'd7 || bus.ghost_y[2:0] !== 3'd0 || bus.moved[0] !== 1'b0)
        $display("FAIL respawn_step%0d got (%0d,%0d) moved=%b want (7,0) moved=0",
                 i, bus.ghost_x[4:0], bus.ghost_y[2:0], bus.moved[0]);
      else n_pass++;
    end
    pulse_step();
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd6 || bus.ghost_y[2:0] !== 3'd0 || bus.moved[0] !== 1'b1)
      $display("FAIL first_move got (%0d,%0d) moved=%b want (6,0) moved=1",
               bus.ghost_x[4:0], bus.ghost_y[2:0], bus.moved[0]);
    else n_pass++;
    n_total++;
    if (bus.ghost_dir[1:0] !== 2'b10) $display("FAIL first_dir got %b want 10", bus.ghost_dir[1:0]);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.moved[0] !== 1'b0) $display("FAIL moved_pulse_width got %b want 0", bus.moved[0]);
    else n_pass++;
  endtask

  task automatic test_heading();
    bus.map[24] = 1'b1;
    set_dir(DOWN);
    pulse_step();
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd5 || bus.ghost_y[2:0] !== 3'd0 || bus.ghost_dir[1:0] !== 2'b10)
      $display("FAIL heading_fallback got (%0d,%0d) dir=%b want (5,0) dir=10",
               bus.ghost_x[4:0], bus.ghost_y[2:0], bus.ghost_dir[1:0]);
    else n_pass++;
    pulse_step();
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd5 || bus.ghost_y[2:0] !== 3'd1 || bus.ghost_dir[1:0] !== 2'b01)
      $display("FAIL heading_relatch got (%0d,%0d) dir=%b want (5,1) dir=01",
               bus.ghost_x[4:0], bus.ghost_y[2:0], bus.ghost_dir[1:0]);
    else n_pass++;
  endtask

  task automatic test_boxed();
    pulse_step();
    set_dir(LEFT);
    repeat (4) pulse_step();
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd1 || bus.ghost_y[2:0] !== 3'd2)
      $display("FAIL boxed_reach got (%0d,%0d) want (1,2)", bus.ghost_x[4:0], bus.ghost_y[2:0]);
    else n_pass++;
    bus.map[19] = 1'b1;
    bus.map[55] = 1'b1;
    bus.map[36] = 1'b1;
    bus.map[38] = 1'b1;
    for (int d = 0; d < 4; d++) begin
      set_dir(2'(d));
      pulse_step();
      n_total++;
      if (bus.ghost_x[4:0] !== 5'd1 || bus.ghost_y[2:0] !== 3'd2 ||
          bus.blocked[0] !== 1'b1 || bus.moved[0] !== 1'b0)
        $display("FAIL boxed_dir%0d got (%0d,%0d) blocked=%b moved=%b want (1,2) blocked=1 moved=0",
                 d, bus.ghost_x[4:0], bus.ghost_y[2:0], bus.blocked[0], bus.moved[0]);
      else n_pass++;
    end
  endtask

  task automatic test_tunnel();
    bus.map = '0;
    set_dir(LEFT);
    pulse_step();
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd0 || bus0.ghost_x[4:0] !== 5'd0 || bus.blocked[0] !== 1'b0)
      $display("FAIL tunnel_edge got x=%0d x0=%0d blocked=%b want 0 0 0",
               bus.ghost_x[4:0], bus0.ghost_x[4:0], bus.blocked[0]);
    else n_pass++;
    pulse_step();
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd17 || bus.ghost_y[2:0] !== 3'd2 || bus.moved[0] !== 1'b1)
      $display("FAIL tunnel_wrap got (%0d,%0d) moved=%b want (17,2) moved=1",
               bus.ghost_x[4:0], bus.ghost_y[2:0], bus.moved[0]);
    else n_pass++;
    n_total++;
    if (bus0.ghost_x[4:0] !== 5'd0 || bus0.blocked[0] !== 1'b1 || bus0.moved[0] !== 1'b0)
      $display("FAIL tunnel_nowrap got x=%0d blocked=%b moved=%b want 0 1 0",
               bus0.ghost_x[4:0], bus0.blocked[0], bus0.moved[0]);
    else n_pass++;
  endtask

  task automatic test_fright();
    logic [4:0] exp_x;
    logic       exp_m;
    bus.frightened = 4'hF;
    @(negedge clk);
    exp_x = 5'd17;
    for (int i = 1; i <= 6; i++) begin
      pulse_step();
      exp_m = (i % 2 == 0);
      if (exp_m) exp_x = exp_x - 5'd1;
      n_total++;
      if (bus.ghost_x[4:0] !== exp_x || bus.moved[0] !== exp_m)
        $display("FAIL fright_step%0d got x=%0d moved=%b want x=%0d moved=%b",
                 i, bus.ghost_x[4:0], bus.moved[0], exp_x, exp_m);
      else n_pass++;
    end
    bus.frightened = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_go_home();
    set_dir(DOWN);
    repeat (2) pulse_step();
    set_dir(LEFT);
    repeat (11) pulse_step();
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd3 || bus.ghost_y[2:0] !== 3'd4)
      $display("FAIL home_reach got (%0d,%0d) want (3,4)", bus.ghost_x[4:0], bus.ghost_y[2:0]);
    else n_pass++;
    @(negedge clk);
    bus.go_home = 4'b0001;
    bus.step    = 1'b1;
    @(negedge clk);
    bus.go_home = 4'b0000;
    bus.step    = 1'b0;
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd7 || bus.ghost_y[2:0] !== 3'd0 ||
        bus.ghost_dir[1:0] !== 2'b00 || bus.moved[0] !== 1'b0)
      $display("FAIL home_jump got (%0d,%0d) dir=%b moved=%b want (7,0) dir=00 moved=0",
               bus.ghost_x[4:0], bus.ghost_y[2:0], bus.ghost_dir[1:0], bus.moved[0]);
    else n_pass++;
    n_total++;
    if (bus.ghost_x[9:5] !== 5'd2 || bus.ghost_y[5:3] !== 3'd4 || bus.moved[1] !== 1'b1)
      $display("FAIL home_other_ghost got (%0d,%0d) moved=%b want (2,4) moved=1",
               bus.ghost_x[9:5], bus.ghost_y[5:3], bus.moved[1]);
    else n_pass++;
    pulse_step();
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd7 || bus.moved[0] !== 1'b0 || bus.ghost_x[9:5] !== 5'd1)
      $display("FAIL home_frozen got x0=%0d moved0=%b x1=%0d want 7 0 1",
               bus.ghost_x[4:0], bus.moved[0], bus.ghost_x[9:5]);
    else n_pass++;
  endtask

  task automatic test_freeze();
    bus.scene = WIN;
    for (int i = 1; i <= 20; i++) begin
      pulse_step();
      n_total++;
      if (bus.moved !== 4'b0000) $display("FAIL freeze_step%0d moved got %b want 0000", i, bus.moved);
      else n_pass++;
    end
    n_total++;
    if (bus.ghost_x[4:0] !== 5'd7 || bus.ghost_y[2:0] !== 3'd0 ||
        bus.ghost_x[9:5] !== 5'd1 || bus.ghost_y[5:3] !== 3'd4)
      $display("FAIL freeze_pos got g0=(%0d,%0d) g1=(%0d,%0d) want (7,0) (1,4)",
               bus.ghost_x[4:0], bus.ghost_y[2:0], bus.ghost_x[9:5], bus.ghost_y[5:3]);
    else n_pass++;
  endtask

  task automatic test_start();
    bus.scene = START;
    @(negedge clk);
    n_total++;
    if (bus.ghost_x !== {4{5'd7}} || bus.ghost_y !== 12'd0 || bus.ghost_dir !== 8'd0)
      $display("FAIL start_home got x=%h y=%h dir=%h want %h 0 0",
               bus.ghost_x, bus.ghost_y, bus.ghost_dir, {4{5'd7}});
    else n_pass++;
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    rst_n          = 1'b0;
    bus.scene      = START;
    bus.step       = 1'b0;
    bus.map        = '0;
    bus.dir_req    = '0;
    bus.go_home    = '0;
    bus.frightened = '0;
    test_reset();
    test_respawn();
    test_heading();
    test_boxed();
    test_tunnel();
    test_fright();
    test_go_home();
    test_freeze();
    test_start();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
